prt_tx_dispatcher: RTL
======================

PRT_TX_DISPATCHER -- requirements
Module: prt_tx_dispatcher

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, byte width; TAG_QUEUE_DEPTH, default 8, pending slot-tag entries (power of 2); OUT_BUF_DEPTH, default 4, output byte buffer entries.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous active-high reset
- tag_push  in  1  enqueue tag_push_slot (frame ready to transmit)
- tag_push_slot  in  6  PRT slot tag to transmit
- tag_queue_full  out  1  tag queue full; pushes ignored
- prt_rd_en  out  1  read one byte from PRT
- prt_rd_slot_tag  out  6  slot tag being read
- prt_rd_data  in  DATA_WIDTH  PRT read byte
- prt_rd_data_valid  in  1  byte valid, one cycle after prt_rd_en
- prt_rd_frame_complete  in  1  all bytes already read, one cycle after prt_rd_en
- tx_data  out  DATA_WIDTH  byte to MAC
- tx_valid  out  1  tx_data valid
- tx_last  out  1  final byte of frame, qualified by tx_valid
- tx_ready  in  1  MAC accepts byte when tx_valid & tx_ready
- tx_busy  out  1  state != IDLE
- frames_sent  out  16  count of frames completed with tx_last accepted
- frame_error  out  1  one-cycle pulse on aborted frame

Function
REQ-004 SHALL keep a FIFO tag queue of TAG_QUEUE_DEPTH; push when tag_push & !tag_queue_full; pop only on entering IDLE after a frame ends.
REQ-005 SHALL implement states IDLE, FETCH, DRAIN.
REQ-006 IDLE: if queue non-empty, latch head tag into prt_rd_slot_tag, go to FETCH next cycle; otherwise stay.
REQ-007 FETCH: assert prt_rd_en only when (buffer occupancy + held byte + reads in flight) < OUT_BUF_DEPTH and no read is in flight; at most one outstanding read.
REQ-008 PRT response SHALL be sampled exactly one cycle after each prt_rd_en.
REQ-009 Response data_valid=1: if a held byte exists, push it to output buffer with last=0; then new byte becomes held byte.
REQ-010 Response frame_complete=1 with held byte: push held byte with last=1, stop issuing reads, go to DRAIN.
REQ-011 Response frame_complete=1 with no held byte (zero-length frame): pulse frame_error, pop tag, go to IDLE; no tx_valid.
REQ-012 Response with both data_valid=0 and frame_complete=0 (invalid or incomplete entry): discard held byte, pulse frame_error, go to DRAIN to flush already-buffered bytes; the last buffered byte SHALL NOT be marked tx_last.
REQ-013 Response with both data_valid=1 and frame_complete=1 SHALL be treated as data_valid only.
REQ-014 DRAIN: wait until output buffer empty, then pop tag and return to IDLE; prt_rd_en=0.
REQ-015 tx_valid = buffer non-empty; tx_data/tx_last from buffer head; head popped on tx_valid & tx_ready; tx_data/tx_last SHALL remain stable while tx_valid & !tx_ready.
REQ-016 Output buffer SHALL never overflow; write and read in same cycle keep occupancy constant.
REQ-017 frames_sent SHALL increment on accepted byte with tx_last=1, wrapping 0xFFFF -> 0.
REQ-018 Minimum throughput with tx_ready held high: one byte per two cycles.
REQ-019 A tag_push in the same cycle as a pop when full SHALL be ignored (full evaluated before pop).

Reset
REQ-020 On reset: state IDLE, queues and buffers empty, held byte cleared, prt_rd_en=0, prt_rd_slot_tag=0, tx_valid=0, tx_last=0, tx_data=0, tx_busy=0, tag_queue_full=0, frames_sent=0, frame_error=0.
REQ-021 Reset mid-frame SHALL abandon the frame with no further tx_valid or prt_rd_en from the next cycle; in-flight PRT response ignored.

Verification
REQ-022 Push tag 5, PRT model returns bytes 0xA1,0xA2,0xA3 then complete, tx_ready=1 -> tx_data A1,A2,A3, tx_last only on A3, frames_sent=1, prt_rd_slot_tag=5.
REQ-023 Same frame, tx_ready toggled 1 cycle on / 3 off -> bytes in order, data stable while stalled, occupancy never > 4.
REQ-024 Push 8 tags then a 9th -> tag_queue_full=1, 9th dropped; frames transmitted in push order 1..8.
REQ-025 Zero-length frame (immediate complete) -> frame_error one cycle, no tx_valid, next tag starts.
REQ-026 Response 0/0 after 2 good bytes -> frame_error, byte 1 emitted without tx_last, byte 2 discarded, frames_sent unchanged.
REQ-027 Assert reset during byte 2 of a 10-byte frame -> all outputs at reset values next cycle, queue empty.

Source files
------------

// File: rtl/prt_tx_dispatcher_if.sv
// Signal bundle between the PRT transmit dispatcher and its surroundings: tag queue
// push side, PRT read port, MAC byte stream and status.
interface prt_tx_dispatcher_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  tag_push;
   logic [5:0]            tag_push_slot;
   logic                  tag_queue_full;
   logic                  prt_rd_en;
   logic [5:0]            prt_rd_slot_tag;
   logic [DATA_WIDTH-1:0] prt_rd_data;
   logic                  prt_rd_data_valid;
   logic                  prt_rd_frame_complete;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_last;
   logic                  tx_ready;
   logic                  tx_busy;
   logic [15:0]           frames_sent;
   logic                  frame_error;

   modport master (
      input  tag_push, tag_push_slot, prt_rd_data, prt_rd_data_valid, prt_rd_frame_complete,
             tx_ready,
      output tag_queue_full, prt_rd_en, prt_rd_slot_tag, tx_data, tx_valid, tx_last, tx_busy,
             frames_sent, frame_error
   );

   modport slave (
      output tag_push, tag_push_slot, prt_rd_data, prt_rd_data_valid, prt_rd_frame_complete,
             tx_ready,
      input  tag_queue_full, prt_rd_en, prt_rd_slot_tag, tx_data, tx_valid, tx_last, tx_busy,
             frames_sent, frame_error
   );
endinterface

// File: rtl/prt_tx_dispatcher.sv
// Transmit dispatcher: dequeues slot tags, reads frame bytes from the PRT one at a time
// and streams them to the MAC through a small output buffer.
module prt_tx_dispatcher #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned TAG_QUEUE_DEPTH = 8,
   parameter int unsigned OUT_BUF_DEPTH   = 4
) (
   input logic                 clk,
   input logic                 reset,
   prt_tx_dispatcher_if.master bus
);
   localparam int unsigned TqAw = (TAG_QUEUE_DEPTH > 1) ? $clog2(TAG_QUEUE_DEPTH) : 1;
   localparam int unsigned ObAw = (OUT_BUF_DEPTH > 1) ? $clog2(OUT_BUF_DEPTH) : 1;
   localparam int unsigned ObCw = $clog2(OUT_BUF_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e                state_q, state_d;
   logic [5:0]            slot_tag_q, slot_tag_d;
   logic                  held_valid_q, held_valid_d;
   logic [DATA_WIDTH-1:0] held_data_q, held_data_d;
   logic                  in_flight_q;
   logic                  frame_error_q, frame_error_d;
   logic [15:0]           frames_sent_q;
   logic                  rd_en;

   logic [5:0]      tq_mem [TAG_QUEUE_DEPTH];
   logic [TqAw-1:0] tq_wptr_q, tq_rptr_q;
   logic [TqAw:0]   tq_cnt_q;
   logic            tq_full, tq_empty, tq_push, tq_pop;

   logic [DATA_WIDTH-1:0] ob_data_mem [OUT_BUF_DEPTH];
   logic                  ob_last_mem [OUT_BUF_DEPTH];
   logic [ObAw-1:0]       ob_wptr_q, ob_rptr_q;
   logic [ObCw-1:0]       ob_cnt_q;
   logic                  ob_nempty, ob_push, ob_push_last, ob_pop, room_ok;

   assign tq_full  = (32'(tq_cnt_q) == TAG_QUEUE_DEPTH);
   assign tq_empty = (tq_cnt_q == '0);
   // Full is judged on the registered count, so a push colliding with a pop when full is lost.
   assign tq_push  = bus.tag_push && !tq_full;

   assign ob_nempty = (ob_cnt_q != '0);
   assign ob_pop    = ob_nempty && bus.tx_ready;
   assign room_ok   = (32'(ob_cnt_q) + 32'(held_valid_q) + 32'(in_flight_q)) < OUT_BUF_DEPTH;

   always_comb begin
      state_d       = state_q;
      slot_tag_d    = slot_tag_q;
      held_valid_d  = held_valid_q;
      held_data_d   = held_data_q;
      frame_error_d = 1'b0;
      rd_en         = 1'b0;
      ob_push       = 1'b0;
      ob_push_last  = 1'b0;
      tq_pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!tq_empty) begin
               slot_tag_d   = tq_mem[tq_rptr_q];
               held_valid_d = 1'b0;
               state_d      = StFetch;
            end
         end
         StFetch: begin
            if (in_flight_q) begin
               // data_valid wins over frame_complete when both are set
               if (bus.prt_rd_data_valid) begin
                  ob_push      = held_valid_q;
                  held_data_d  = bus.prt_rd_data;
                  held_valid_d = 1'b1;
               end else if (bus.prt_rd_frame_complete) begin
                  if (held_valid_q) begin
                     ob_push      = 1'b1;
                     ob_push_last = 1'b1;
                     held_valid_d = 1'b0;
                     state_d      = StDrain;
                  end else begin
                     frame_error_d = 1'b1;
                     tq_pop        = 1'b1;
                     state_d       = StIdle;
                  end
               end else begin
                  held_valid_d  = 1'b0;
                  frame_error_d = 1'b1;
                  state_d       = StDrain;
               end
            end else begin
               rd_en = room_ok;
            end
         end
         StDrain: begin
            if (!ob_nempty) begin
               tq_pop  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         slot_tag_q    <= '0;
         held_valid_q  <= 1'b0;
         held_data_q   <= '0;
         in_flight_q   <= 1'b0;
         frame_error_q <= 1'b0;
         frames_sent_q <= '0;
      end else begin
         state_q       <= state_d;
         slot_tag_q    <= slot_tag_d;
         held_valid_q  <= held_valid_d;
         held_data_q   <= held_data_d;
         in_flight_q   <= rd_en;
         frame_error_q <= frame_error_d;
         if (ob_pop && ob_last_mem[ob_rptr_q]) frames_sent_q <= frames_sent_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tq_wptr_q <= '0;
         tq_rptr_q <= '0;
         tq_cnt_q  <= '0;
         ob_wptr_q <= '0;
         ob_rptr_q <= '0;
         ob_cnt_q  <= '0;
      end else begin
         if (tq_push) tq_wptr_q <= (32'(tq_wptr_q) == TAG_QUEUE_DEPTH - 1) ? '0 : tq_wptr_q + TqAw'(1);
         if (tq_pop)  tq_rptr_q <= (32'(tq_rptr_q) == TAG_QUEUE_DEPTH - 1) ? '0 : tq_rptr_q + TqAw'(1);
         case ({tq_push, tq_pop})
            2'b10:   tq_cnt_q <= tq_cnt_q + (TqAw + 1)'(1);
            2'b01:   tq_cnt_q <= tq_cnt_q - (TqAw + 1)'(1);
            default: ;
         endcase
         if (ob_push) ob_wptr_q <= (32'(ob_wptr_q) == OUT_BUF_DEPTH - 1) ? '0 : ob_wptr_q + ObAw'(1);
         if (ob_pop)  ob_rptr_q <= (32'(ob_rptr_q) == OUT_BUF_DEPTH - 1) ? '0 : ob_rptr_q + ObAw'(1);
         case ({ob_push, ob_pop})
            2'b10:   ob_cnt_q <= ob_cnt_q + ObCw'(1);
            2'b01:   ob_cnt_q <= ob_cnt_q - ObCw'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tq_push) tq_mem[tq_wptr_q] <= bus.tag_push_slot;
      if (ob_push) begin
         ob_data_mem[ob_wptr_q] <= held_data_q;
         ob_last_mem[ob_wptr_q] <= ob_push_last;
      end
   end

   assign bus.tag_queue_full  = tq_full;
   assign bus.prt_rd_en       = rd_en;
   assign bus.prt_rd_slot_tag = slot_tag_q;
   assign bus.tx_valid        = ob_nempty;
   assign bus.tx_data         = ob_nempty ? ob_data_mem[ob_rptr_q] : '0;
   assign bus.tx_last         = ob_nempty ? ob_last_mem[ob_rptr_q] : 1'b0;
   assign bus.tx_busy         = (state_q != StIdle);
   assign bus.frames_sent     = frames_sent_q;
   assign bus.frame_error     = frame_error_q;
endmodule
